// File: rtl/mem_stage_param_if.sv
// M-stage bus: E/M register inputs, W-register control, and the W-register / merged outputs.
// m_busy is a stall request: while it is 1 the upstream stages keep every M_* input stable and the
// W register holds; the access completes on the first cycle with m_busy = 0 and W_stall = 0.
interface mem_stage_param_if #(
    parameter int DATA_W = 64
);
    logic [1:0]        M_stat;
    logic [3:0]        M_in_code;
    logic [DATA_W-1:0] M_val_e;
    logic [DATA_W-1:0] M_val_a;
    logic [3:0]        M_dst_e;
    logic [3:0]        M_dst_m;
    logic              W_stall;
    logic              W_bubble;
    logic [1:0]        m_stat;
    logic [DATA_W-1:0] m_val_m;
    logic              m_busy;
    logic [1:0]        W_stat;
    logic [3:0]        W_in_code;
    logic [DATA_W-1:0] W_val_e;
    logic [DATA_W-1:0] W_val_m;
    logic [3:0]        W_dst_e;
    logic [3:0]        W_dst_m;

    modport master (
        output M_stat, M_in_code, M_val_e, M_val_a, M_dst_e, M_dst_m, W_stall, W_bubble,
        input  m_stat, m_val_m, m_busy, W_stat, W_in_code, W_val_e, W_val_m, W_dst_e, W_dst_m
    );

    modport slave (
        input  M_stat, M_in_code, M_val_e, M_val_a, M_dst_e, M_dst_m, W_stall, W_bubble,
        output m_stat, m_val_m, m_busy, W_stat, W_in_code, W_val_e, W_val_m, W_dst_e, W_dst_m
    );
endinterface

// File: rtl/mem_stage_param.sv
// Y86-64 memory stage with word-addressed data memory, range checking, status merging,
// configurable multi-cycle access latency and the W pipeline register.
module mem_stage_param #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1,
    parameter int INIT_EN = 1
) (
    input logic               clock,
    input logic               reset,
    mem_stage_param_if.slave  bus
);
    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [2:0] LAST  = 3'(MEM_LAT - 1);

    typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

    function automatic mem_t init_image();
        mem_t img = '0;
        if (INIT_EN != 0) begin
            for (int i = 0; i < 27; i++) begin
                if (i < DEPTH) img[i] = DATA_W'(2 * (i + 1));
            end
        end
        return img;
    endfunction

    // Power-up contents; reset deliberately leaves the array untouched.
    mem_t r_mem = init_image();

    logic [2:0]        r_cnt;
    logic [3:0]        r_icode_q;
    logic              w_is_write;
    logic              w_is_read;
    logic [DATA_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_idx;
    logic              w_addr_err;
    logic              w_acc_valid;
    logic [2:0]        w_cnt_eff;
    logic              w_busy;
    logic              w_we;
    logic [DATA_W-1:0] w_rdata;

    always_comb begin
        w_is_write = (bus.M_in_code == 4'd4) || (bus.M_in_code == 4'd10) || (bus.M_in_code == 4'd8);
        w_is_read  = (bus.M_in_code == 4'd5) || (bus.M_in_code == 4'd9) || (bus.M_in_code == 4'd11);
        // ret and popq address the stack through val_a; everything else uses val_e.
        w_addr     = ((bus.M_in_code == 4'd9) || (bus.M_in_code == 4'd11)) ? bus.M_val_a : bus.M_val_e;
        w_idx      = w_addr[ADDR_W-1:0];
        w_addr_err = (w_is_write || w_is_read) && (|w_addr[DATA_W-1:ADDR_W]);
        w_acc_valid = (w_is_write || w_is_read) && !w_addr_err && (bus.M_stat == 2'b00);
        // A change of instruction mid-access throws away the partial count.
        w_cnt_eff  = ((r_cnt != 3'd0) && (bus.M_in_code != r_icode_q)) ? 3'd0 : r_cnt;
        w_busy     = w_acc_valid && (w_cnt_eff < LAST);
        w_we       = w_is_write && w_acc_valid && !w_busy && !bus.W_stall;
        w_rdata    = (w_is_read && w_acc_valid) ? r_mem[w_idx] : '0;
    end

    assign bus.m_stat  = w_addr_err ? 2'b10 : bus.M_stat;
    assign bus.m_val_m = w_rdata;
    assign bus.m_busy  = w_busy;

    always_ff @(posedge clock) begin
        if (!reset && w_we) r_mem[w_idx] <= bus.M_val_a;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt     <= 3'd0;
            r_icode_q <= 4'd1;
        end else begin
            r_icode_q <= bus.M_in_code;
            if (!w_acc_valid)    r_cnt <= 3'd0;
            else if (w_busy)     r_cnt <= w_cnt_eff + 3'd1;
            else if (bus.W_stall) r_cnt <= w_cnt_eff;
            else                 r_cnt <= 3'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || (!bus.W_stall && !w_busy && bus.W_bubble)) begin
            bus.W_stat    <= 2'b00;
            bus.W_in_code <= 4'd1;
            bus.W_val_e   <= '0;
            bus.W_val_m   <= '0;
            bus.W_dst_e   <= 4'hF;
            bus.W_dst_m   <= 4'hF;
        end else if (!bus.W_stall && !w_busy) begin
            bus.W_stat    <= bus.m_stat;
            bus.W_in_code <= bus.M_in_code;
            bus.W_val_e   <= bus.M_val_e;
            bus.W_val_m   <= w_rdata;
            bus.W_dst_e   <= bus.M_dst_e;
            bus.W_dst_m   <= bus.M_dst_m;
        end
    end
endmodule
